// File: rtl/mmu_hs_pkg.sv
// Shared handshake definitions for the MMU drive/free blocks.
// FSM state codes and the branch count of the 3-way splitter/join.
package mmu_hs_pkg;

    localparam int HS_PORTS = 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_FIRE    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

endpackage

// File: rtl/hs_arrival_slot.sv
// One join input: arrival flag, captured data word, and the
// per-branch protocol check (duplicate or out-of-phase drive).
module hs_arrival_slot
    import mmu_hs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              drive,
    input  logic [DATA_W-1:0] data,
    input  logic              accOpen,
    input  logic              clear,
    output logic              arrived,
    output logic              accept,
    output logic              violation,
    output logic [DATA_W-1:0] word
);

    assign accept    = drive && accOpen && !arrived;
    assign violation = drive && (!accOpen || arrived);

    // Capture the first token per round; RELEASE re-arms the slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arrived <= 1'b0;
            word    <= '0;
        end else if (clear) begin
            arrived <= 1'b0;
        end else if (accept) begin
            arrived <= 1'b1;
            word    <= data;
        end
    end

endmodule

// File: rtl/cjoin3_sync_mmu.sv
// Clocked 3-way join for the MMU drive/free handshake.
// Waits for all three branch tokens, fires once, returns free.
module cjoin3_sync_mmu
    import mmu_hs_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int STALL_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_drive0,
    input  logic                  i_drive1,
    input  logic                  i_drive2,
    input  logic [DATA_W-1:0]     i_data0,
    input  logic [DATA_W-1:0]     i_data1,
    input  logic [DATA_W-1:0]     i_data2,
    output logic                  o_free0,
    output logic                  o_free1,
    output logic                  o_free2,
    output logic                  o_driveNext,
    output logic [3*DATA_W-1:0]   o_dataNext,
    input  logic                  i_freeNext,
    output logic                  o_busy,
    output logic                  o_stall,
    output logic                  o_err
);

    logic [2:0]          state;
    logic [2:0]          nextState;
    logic [HS_PORTS-1:0] drv;
    logic [HS_PORTS-1:0] arr;
    logic [HS_PORTS-1:0] acc;
    logic [HS_PORTS-1:0] vio;
    logic [HS_PORTS-1:0] nextArr;
    logic [DATA_W-1:0]   dIn  [HS_PORTS];
    logic [DATA_W-1:0]   word [HS_PORTS];
    logic [STALL_W-1:0]  cnt;
    logic [STALL_W-1:0]  cntNext;
    logic                accOpen;
    logic                clear;
    logic                freeErr;
    logic                freeQ;

    assign drv     = {i_drive2, i_drive1, i_drive0};
    assign dIn[0]  = i_data0;
    assign dIn[1]  = i_data1;
    assign dIn[2]  = i_data2;
    assign accOpen = (state == S_IDLE) || (state == S_COLLECT);
    assign clear   = (state == S_RELEASE);
    assign nextArr = arr | acc;
    assign freeErr = i_freeNext &&
                     !((state == S_FIRE) || (state == S_WAIT));

    for (genvar k = 0; k < HS_PORTS; k++) begin : gSlot
        hs_arrival_slot #(
            .DATA_W (DATA_W)
        ) uSlot (
            .clk       (clk),
            .rstn      (rstn),
            .drive     (drv[k]),
            .data      (dIn[k]),
            .accOpen   (accOpen),
            .clear     (clear),
            .arrived   (arr[k]),
            .accept    (acc[k]),
            .violation (vio[k]),
            .word      (word[k])
        );
    end

    assign o_dataNext = {word[2], word[1], word[0]};
    assign o_free0    = freeQ;
    assign o_free1    = freeQ;
    assign o_free2    = freeQ;

    // Next-state decode for the join round.
    always_comb begin
        nextState = S_IDLE;
        unique case (1'b1)
            accOpen: begin
                if (&nextArr)
                    nextState = S_FIRE;
                else if (|nextArr)
                    nextState = S_COLLECT;
                else
                    nextState = S_IDLE;
            end
            state == S_FIRE,
            state == S_WAIT:
                nextState = i_freeNext ? S_RELEASE : S_WAIT;
            state == S_RELEASE:
                nextState = S_IDLE;
            default:
                nextState = S_IDLE;
        endcase
    end

    // Watchdog: count COLLECT cycles, saturate, clear on FIRE.
    always_comb begin
        cntNext = cnt;
        if (nextState == S_FIRE)
            cntNext = '0;
        else if ((state == S_COLLECT) && !(&cnt))
            cntNext = cnt + 1'b1;
    end

    // State, counter and registered status/handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            o_driveNext <= 1'b0;
            freeQ       <= 1'b0;
            o_busy      <= 1'b0;
            o_stall     <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state       <= nextState;
            cnt         <= cntNext;
            o_driveNext <= (nextState == S_FIRE);
            freeQ       <= (nextState == S_RELEASE);
            o_busy      <= (nextState != S_IDLE);
            o_stall     <= (nextState == S_COLLECT) && (&cntNext);
            if ((|vio) || freeErr)
                o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cjoin3_sync_mmu.sv
// Bench for cjoin3_sync_mmu: vector table, directed corners,
// and random traffic against a transaction-level model.
module tb_cjoin3_sync_mmu;

    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_drive0 = 0, i_drive1 = 0, i_drive2 = 0;
    logic [DW-1:0] i_data0 = 0, i_data1 = 0, i_data2 = 0;
    logic          i_freeNext = 0;
    logic          o_free0, o_free1, o_free2;
    logic          o_driveNext;
    logic [3*DW-1:0] o_dataNext;
    logic          o_busy, o_stall, o_err;

    int checks = 0;
    int errors = 0;

    cjoin3_sync_mmu #(.DATA_W(DW), .STALL_W(SW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_drive0    (i_drive0),
        .i_drive1    (i_drive1),
        .i_drive2    (i_drive2),
        .i_data0     (i_data0),
        .i_data1     (i_data1),
        .i_data2     (i_data2),
        .o_free0     (o_free0),
        .o_free1     (o_free1),
        .o_free2     (o_free2),
        .o_driveNext (o_driveNext),
        .o_dataNext  (o_dataNext),
        .i_freeNext  (i_freeNext),
        .o_busy      (o_busy),
        .o_stall     (o_stall),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    // Reference model: which branches hold a token, whether the
    // combined token is outstanding, and whether free is due.
    bit [2:0]      mGot;
    logic [DW-1:0] mVal [3];
    bit            mFire, mOut, mRel, mErr;
    int            mColl;

    task automatic modelReset();
        mGot = 0; mFire = 0; mOut = 0; mRel = 0; mErr = 0;
        mColl = 0;
        for (int k = 0; k < 3; k++) mVal[k] = '0;
    endtask

    task automatic modelStep(input bit [2:0] d,
                             input logic [DW-1:0] a, b, c,
                             input bit fn);
        logic [DW-1:0] dv [3];
        bit gathering, wasColl;
        dv[0] = a; dv[1] = b; dv[2] = c;
        gathering = !mOut && !mRel;
        wasColl = gathering && (mGot != 0);
        if (fn && !mOut) mErr = 1;
        mFire = 0;
        if (gathering) begin
            if ((d & mGot) != 0) mErr = 1;
            for (int k = 0; k < 3; k++)
                if (d[k] && !mGot[k]) begin
                    mGot[k] = 1;
                    mVal[k] = dv[k];
                end
            if (mGot == 3'b111) begin
                mFire = 1; mOut = 1; mColl = 0;
            end else if (wasColl && mColl < SMAX) begin
                mColl++;
            end
        end else begin
            if (d != 0) mErr = 1;
            if (mRel) begin
                mRel = 0; mGot = 0;
            end else if (fn) begin
                mOut = 0; mRel = 1;
            end
        end
    endtask

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string name);
        bit stl, bsy;
        logic [127:0] a, e;
        stl = !mOut && !mRel && mGot != 0 && mGot != 3'b111 &&
              mColl == SMAX;
        bsy = (mGot != 0) || mOut || mRel;
        a = {25'd0, o_driveNext, o_free0, o_free1, o_free2,
             o_busy, o_stall, o_err, o_dataNext};
        e = {25'd0, mFire, mRel, mRel, mRel, bsy, stl, mErr,
             mVal[2], mVal[1], mVal[0]};
        chk(name, a, e);
    endtask

    task automatic step(input logic [2:0] d,
                        input logic [DW-1:0] a, b, c,
                        input logic fn);
        i_drive0 = d[0]; i_drive1 = d[1]; i_drive2 = d[2];
        i_data0 = a; i_data1 = b; i_data2 = c;
        i_freeNext = fn;
        @(posedge clk);
        #1;
        modelStep(d, a, b, c, fn);
        checkModel("model");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 0, 0, 0, 1'b0);
    endtask

    task automatic doReset();
        i_drive0 = 0; i_drive1 = 0; i_drive2 = 0;
        i_freeNext = 0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        chk("reset", {o_driveNext, o_free0, o_free1, o_free2,
                      o_busy, o_stall, o_err, o_dataNext}, '0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]    d;
        logic [DW-1:0] d0, d1, d2;
        logic          fn;
        logic          eDrv, eFree, eBusy, eErr, chkD;
        logic [3*DW-1:0] eData;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] d,
                                input logic [DW-1:0] d0, d1, d2,
                                input logic fn,
                                input logic eDrv, eFree,
                                input logic eBusy, eErr,
                                input logic chkD,
                                input logic [3*DW-1:0] eData);
        vec_t v;
        v.d = d; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.fn = fn;
        v.eDrv = eDrv; v.eFree = eFree; v.eBusy = eBusy;
        v.eErr = eErr; v.chkD = chkD; v.eData = eData;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        tbl[0]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(3'b111, 32'h11, 32'h22, 32'h33, 0,
                     1, 0, 1, 0, 1, {32'h33, 32'h22, 32'h11});
        tbl[2]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1,
                     {32'h33, 32'h22, 32'h11});
        tbl[4]  = mk(3'b000, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        tbl[5]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(3'b111, 32'h44, 32'h55, 32'h66, 0,
                     1, 0, 1, 0, 1, {32'h66, 32'h55, 32'h44});
        tbl[7]  = mk(3'b000, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        tbl[8]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(3'b001, 32'hAA, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[10] = mk(3'b001, 32'hBB, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[11] = mk(3'b110, 0, 32'hCC, 32'hDD, 0,
                     1, 0, 1, 1, 1, {32'hDD, 32'hCC, 32'hAA});
        tbl[12] = mk(3'b000, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
        tbl[13] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        modelReset();
        doReset();

        // Vector table: simultaneous arrival, immediate free,
        // duplicate drive keeps the first data word.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].d, tbl[i].d0, tbl[i].d1, tbl[i].d2,
                 tbl[i].fn);
            chk($sformatf("tbl%0d.drv", i), o_driveNext,
                tbl[i].eDrv);
            chk($sformatf("tbl%0d.free", i),
                {o_free2, o_free1, o_free0}, {3{tbl[i].eFree}});
            chk($sformatf("tbl%0d.busy", i), o_busy, tbl[i].eBusy);
            chk($sformatf("tbl%0d.err", i), o_err, tbl[i].eErr);
            if (tbl[i].chkD)
                chk($sformatf("tbl%0d.data", i), o_dataNext,
                    tbl[i].eData);
        end

        // Staggered arrival.
        doReset();
        step(3'b010, 0, 32'h2, 0, 0);
        chk("stag.busy1", o_busy, 1'b1);
        idle(3);
        step(3'b001, 32'h1, 0, 0, 0);
        chk("stag.nofire", o_driveNext, 1'b0);
        idle(10);
        chk("stag.busy2", o_busy, 1'b1);
        step(3'b100, 0, 0, 32'h3, 0);
        chk("stag.fire", o_driveNext, 1'b1);
        chk("stag.data", o_dataNext, {32'h3, 32'h2, 32'h1});
        step(3'b000, 0, 0, 0, 1);
        chk("stag.free", {o_free2, o_free1, o_free0}, 3'b111);
        chk("stag.busy3", o_busy, 1'b1);
        idle(1);
        chk("stag.idle", o_busy, 1'b0);
        chk("stag.err", o_err, 1'b0);

        // Stray free in IDLE.
        step(3'b000, 0, 0, 0, 1);
        chk("stray.err", o_err, 1'b1);
        idle(2);
        chk("stray.sticky", o_err, 1'b1);

        // Watchdog on partial arrival.
        doReset();
        step(3'b100, 0, 0, 32'h9, 0);
        idle(14);
        chk("wd.pre", o_stall, 1'b0);
        idle(1);
        chk("wd.hit", o_stall, 1'b1);
        idle(2);
        chk("wd.sat", o_stall, 1'b1);
        step(3'b011, 32'h7, 32'h8, 0, 0);
        chk("wd.fire", o_driveNext, 1'b1);
        chk("wd.clr", o_stall, 1'b0);
        step(3'b000, 0, 0, 0, 1);
        idle(1);
        step(3'b010, 0, 32'h5, 0, 0);
        idle(14);
        chk("wd.restart", o_stall, 1'b0);
        idle(1);
        chk("wd.rehit", o_stall, 1'b1);

        // Asynchronous reset while waiting for downstream free.
        doReset();
        step(3'b000, 0, 0, 0, 1);
        chk("ar.err", o_err, 1'b1);
        step(3'b111, 32'hA1, 32'hB2, 32'hC3, 0);
        idle(1);
        chk("ar.wait", o_busy, 1'b1);
        rstn = 1'b0;
        #2;
        chk("ar.async", {o_driveNext, o_free0, o_free1, o_free2,
                         o_busy, o_stall, o_err, o_dataNext}, '0);
        #2;
        rstn = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        step(3'b111, 32'h1, 32'h2, 32'h3, 0);
        chk("ar.fresh", o_driveNext, 1'b1);
        step(3'b000, 0, 0, 0, 1);
        chk("ar.free", {o_free2, o_free1, o_free0}, 3'b111);
        idle(1);
        chk("ar.noerr", o_err, 1'b0);

        // Random traffic, mostly legal, occasional violations.
        doReset();
        for (int i = 0; i < 600; i++) begin
            logic [2:0] d;
            logic fn;
            if (i % 150 == 0) doReset();
            for (int k = 0; k < 3; k++)
                d[k] = ($urandom_range(0, 5) == 0);
            if (mOut || mRel)
                if ($urandom_range(0, 15) != 0) d = 0;
            if (mOut)
                fn = ($urandom_range(0, 2) == 0);
            else
                fn = ($urandom_range(0, 40) == 0);
            step(d, $urandom, $urandom, $urandom, fn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
